tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
Time-division demultiplexer, the receive end of a mux-based serial link.
- Accepts a word-serial stream in which slot 0 of each frame is flagged by frame_sync.
- Distributes N_CH consecutive slots into per-channel registers and presents each complete frame in parallel with a one-cycle strobe.
- Sits after the channel multiplexer and serial link; feeds the per-channel consumers.

Parameters:
N_CH, 4, number of channels/slots per frame (>= 2)
W, 8, data width per slot in bits
SW, $clog2(N_CH), slot index width (local, derived)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data/frame_sync qualify this cycle
frame_sync  input  1  current word is slot 0 (meaningful only with in_valid)
in_data  input  W  serial slot word
out_data  output  N_CH*W  completed frame; channel k at bits [k*W +: W]
out_valid  output  1  one-cycle pulse: out_data updated with a new frame
slot_idx  output  SW  slot index the next accepted word will occupy
locked  output  1  frame alignment held
sync_err  output  1  one-cycle pulse on alignment violation

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low (rst_n), released synchronously to clk.
- Reset values:
  - out_data = 0
  - out_valid = 0
  - slot_idx = 0
  - locked = 0
  - sync_err = 0
  - shadow buffer = 0
  - state = HUNT
- Accepted word: a word is accepted in any cycle with in_valid=1. When in_valid=0, all state holds.
- FSM states: HUNT, LOCKED.
- HUNT:
  - Words without frame_sync are discarded. slot_idx stays 0.
  - An accepted word with frame_sync=1 writes shadow[0], sets slot_idx=1 and enters LOCKED. locked=1 from the next cycle.
- LOCKED:
  - An accepted word with frame_sync=0 and slot_idx != 0 writes shadow[slot_idx] and increments slot_idx.
  - Accepting slot N_CH-1 wraps slot_idx to 0. In the next cycle out_data = the full shadow content and out_valid=1 for exactly one cycle.
  - The slot-0 word is written to shadow[0] on the same edge, so shadow is effectively double-buffered against out_data.
  - Early sync: frame_sync=1 with slot_idx != 0.
    - sync_err pulses for one cycle and the partial frame is discarded (no out_valid).
    - The word is taken as a new slot 0: shadow[0] is written, slot_idx=1, state stays LOCKED.
  - Missing sync: frame_sync=0 with slot_idx == 0.
    - sync_err pulses, the word is discarded and the state goes to HUNT. locked=0 next cycle; slot_idx stays 0.
  - frame_sync=1 with slot_idx == 0 is a normal frame start.
- Latency: out_valid rises on the cycle after the edge that accepts slot N_CH-1 (one cycle). out_data is stable until the next out_valid.
- Back-to-back frames: with continuous in_valid, out_valid pulses every N_CH cycles. A frame_sync on the cycle after last-slot acceptance is legal.
- out_valid and sync_err are never asserted together, because any error discards the frame.
- Reset mid-frame: the partial frame is lost, out_data clears, and no pulse is generated.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package: N_CH/W defaults, SW derivation, FSM state encoding (HUNT=1'b0, LOCKED=1'b1).
- Sub-module: tdm_slot_counter. Modulo-N_CH counter with load-to-1 (sync restart), clear, enable and a wrap flag. Reused by the matching transmit-side mux.

Test Plan:
1. Reset; then in_valid=1 continuously, frame_sync on words 0x11 (sync), 0x22, 0x33, 0x44 -> one cycle after 0x44, out_valid=1 and out_data=0x44332211; locked=1 from cycle after 0x11.
2. Three back-to-back frames (0xA0..A3, 0xB0..B3, 0xC0..C3) with continuous valid -> out_valid pulses exactly every 4 cycles, out_data = 0xA3A2A1A0, 0xB3B2B1B0, 0xC3C2C1C0; sync_err never set.
3. in_valid toggling 1/0 inside a frame (gaps of 1-3 cycles) with data 0x01..0x04 -> slot_idx holds during gaps; out_data=0x04030201 once.
4. Early sync: slots 0x10,0x20 then frame_sync with 0x55, then 0x66,0x77,0x88 -> sync_err one pulse at the 0x55 edge, no out_valid for the partial frame, then out_valid with out_data=0x88776655.
5. Missing sync: full frame, then next word 0x99 with frame_sync=0 -> sync_err pulse, locked=0, following non-sync words ignored; frame_sync restores locked.
6. Assert rst_n=0 asynchronously (mid-cycle) after slot 2 -> all outputs 0 immediately; after release a full frame 0xDEADBEEF is received correctly without a stale-slot pulse.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer and its slot counter:
// default geometry, slot index width derivation and FSM state encoding.
package tdm_demux_pkg;

    localparam int N_CH_DEFAULT = 4;
    localparam int W_DEFAULT    = 8;

    // Frame alignment state: searching for a sync word, or tracking slots.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Width of a slot index able to address n slots (never narrower than 1).
    function automatic int slotWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N_CH slot counter with clear, load-to-1 (restart after a sync word)
// and increment. wrap_o flags that an increment is leaving the last slot.
module tdm_slot_counter #(
    parameter int N_CH = 4,
    parameter int SW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          load1_i,
    input  logic          clr_i,
    output logic [SW-1:0] count_o,
    output logic          wrap_o
);

    localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

    logic [SW-1:0] count_q;
    logic [SW-1:0] count_d;

    assign wrap_o  = en_i && !clr_i && !load1_i && (count_q == LAST_SLOT);
    assign count_o = count_q;

    // Next count: clear beats restart, restart beats increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = SW'(1);
        end else if (en_i) begin
            count_d = (count_q == LAST_SLOT) ? '0 : count_q + SW'(1);
        end
    end

    // Slot count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the TDM link: aligns on frame_sync, collects N_CH slot
// words into a shadow buffer and publishes each complete frame in parallel
// with a one-cycle out_valid strobe. Alignment faults pulse sync_err.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int W    = W_DEFAULT,
    localparam int SW  = slotWidth(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              frame_sync,
    input  logic [W-1:0]      in_data,
    output logic [N_CH*W-1:0] out_data,
    output logic              out_valid,
    output logic [SW-1:0]     slot_idx,
    output logic              locked,
    output logic              sync_err
);

    state_e              state_q,    state_d;
    logic [N_CH*W-1:0]   shadow_q,   shadow_d;
    logic [N_CH*W-1:0]   outData_q,  outData_d;
    logic                outValid_q, outValid_d;
    logic                syncErr_q,  syncErr_d;

    logic                cntEn;
    logic                cntLoad1;
    logic                cntClr;
    logic                cntWrap;
    logic [SW-1:0]       slotIdx;

    tdm_slot_counter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (cntEn),
        .load1_i (cntLoad1),
        .clr_i   (cntClr),
        .count_o (slotIdx),
        .wrap_o  (cntWrap)
    );

    // Alignment decisions for the accepted word. The frame is published from
    // shadow_d so the last slot lands in out_data on the same edge it arrives,
    // while slot 0 of the next frame may already be overwriting shadow_q.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        outData_d  = outData_q;
        outValid_d = 1'b0;
        syncErr_d  = 1'b0;
        cntEn      = 1'b0;
        cntLoad1   = 1'b0;
        cntClr     = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0 +: W] = in_data;
                        cntLoad1         = 1'b1;
                        state_d          = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        shadow_d[0 +: W] = in_data;
                        cntLoad1         = 1'b1;
                        syncErr_d        = (slotIdx != '0);
                    end else if (slotIdx == '0) begin
                        syncErr_d = 1'b1;
                        cntClr    = 1'b1;
                        state_d   = HUNT;
                    end else begin
                        shadow_d[int'(slotIdx) * W +: W] = in_data;
                        cntEn                            = 1'b1;
                        if (cntWrap) begin
                            outData_d  = shadow_d;
                            outValid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State, shadow buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            shadow_q   <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            syncErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            syncErr_q  <= syncErr_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign slot_idx  = slotIdx;
    assign locked    = (state_q == LOCKED);
    assign sync_err  = syncErr_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: a frame-level reference model is
// compared against the DUT after every clock edge, and directed scenarios
// pin key outputs to hand-computed values.
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int SW   = 2;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              in_valid   = 1'b0;
    logic              frame_sync = 1'b0;
    logic [W-1:0]      in_data    = '0;
    logic [N_CH*W-1:0] out_data;
    logic              out_valid;
    logic [SW-1:0]     slot_idx;
    logic              locked;
    logic              sync_err;

    int nChecks     = 0;
    int nFail       = 0;
    int validPulses = 0;
    int errPulses   = 0;

    // Reference model state
    logic              mLocked = 1'b0;
    int                mSlot   = 0;
    logic [W-1:0]      mBuf [N_CH];
    logic [N_CH*W-1:0] mOut    = '0;
    logic              mValid  = 1'b0;
    logic              mErr    = 1'b0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .slot_idx   (slot_idx),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drive one word; returns at the negedge after the edge that took it.
    task automatic applyStimulus(input logic [W-1:0] data, input logic sync);
        in_valid   = 1'b1;
        frame_sync = sync;
        in_data    = data;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: frame-level receive rules applied per accepted word.
    initial begin
        for (int k = 0; k < N_CH; k++) mBuf[k] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mLocked = 1'b0;
                mSlot   = 0;
                mOut    = '0;
                mValid  = 1'b0;
                mErr    = 1'b0;
                for (int k = 0; k < N_CH; k++) mBuf[k] = '0;
            end else begin
                mValid = 1'b0;
                mErr   = 1'b0;
                if (in_valid) begin
                    if (frame_sync) begin
                        if (mLocked && mSlot != 0) mErr = 1'b1;
                        mBuf[0] = in_data;
                        mSlot   = 1;
                        mLocked = 1'b1;
                    end else if (mLocked) begin
                        if (mSlot == 0) begin
                            mErr    = 1'b1;
                            mLocked = 1'b0;
                        end else begin
                            mBuf[mSlot] = in_data;
                            mSlot       = mSlot + 1;
                            if (mSlot == N_CH) begin
                                mSlot  = 0;
                                mValid = 1'b1;
                                for (int k = 0; k < N_CH; k++) mOut[k*W +: W] = mBuf[k];
                            end
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                checkOutput("model out_valid", 64'(out_valid), 64'(mValid));
                checkOutput("model sync_err",  64'(sync_err),  64'(mErr));
                checkOutput("model locked",    64'(locked),    64'(mLocked));
                checkOutput("model slot_idx",  64'(slot_idx),  64'(mSlot));
                checkOutput("model out_data",  64'(out_data),  64'(mOut));
                if (out_valid) validPulses++;
                if (sync_err)  errPulses++;
            end
        end
    end

    logic [31:0] frameExp [3];
    int v0;
    int e0;

    initial begin
        frameExp[0] = 32'hA3A2A1A0;
        frameExp[1] = 32'hB3B2B1B0;
        frameExp[2] = 32'hC3C2C1C0;

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        checkOutput("reset out_data",  64'(out_data),  64'h0);
        checkOutput("reset out_valid", 64'(out_valid), 64'h0);
        checkOutput("reset slot_idx",  64'(slot_idx),  64'h0);
        checkOutput("reset locked",    64'(locked),    64'h0);
        checkOutput("reset sync_err",  64'(sync_err),  64'h0);

        // Scenario 1: first frame after reset
        applyStimulus(8'h11, 1'b1);
        checkOutput("t1 locked",   64'(locked),   64'h1);
        checkOutput("t1 slot_idx", 64'(slot_idx), 64'h1);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        checkOutput("t1 out_valid", 64'(out_valid), 64'h1);
        checkOutput("t1 out_data",  64'(out_data),  64'h44332211);
        checkOutput("t1 wrap slot", 64'(slot_idx),  64'h0);
        idle(2);
        checkOutput("t1 data held", 64'(out_data),  64'h44332211);

        // Scenario 2: three back-to-back frames
        v0 = validPulses;
        e0 = errPulses;
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < N_CH; s++) begin
                applyStimulus(8'((8'hA0 + 8'h10 * f) + s), s == 0);
            end
            checkOutput("t2 out_valid", 64'(out_valid), 64'h1);
            checkOutput("t2 out_data",  64'(out_data),  64'(frameExp[f]));
        end
        idle(1);
        checkOutput("t2 pulse count", 64'(validPulses - v0), 64'd3);
        checkOutput("t2 err count",   64'(errPulses - e0),   64'd0);

        // Scenario 3: gaps inside a frame
        applyStimulus(8'h01, 1'b1);
        idle(1);
        checkOutput("t3 gap slot1", 64'(slot_idx), 64'h1);
        applyStimulus(8'h02, 1'b0);
        idle(3);
        checkOutput("t3 gap slot2", 64'(slot_idx), 64'h2);
        applyStimulus(8'h03, 1'b0);
        idle(2);
        applyStimulus(8'h04, 1'b0);
        checkOutput("t3 out_valid", 64'(out_valid), 64'h1);
        checkOutput("t3 out_data",  64'(out_data),  64'h04030201);
        idle(1);

        // Scenario 4: early sync restarts the frame
        v0 = validPulses;
        e0 = errPulses;
        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h55, 1'b1);
        checkOutput("t4 sync_err",  64'(sync_err),  64'h1);
        checkOutput("t4 no valid",  64'(out_valid), 64'h0);
        checkOutput("t4 slot_idx",  64'(slot_idx),  64'h1);
        checkOutput("t4 locked",    64'(locked),    64'h1);
        applyStimulus(8'h66, 1'b0);
        applyStimulus(8'h77, 1'b0);
        applyStimulus(8'h88, 1'b0);
        checkOutput("t4 out_valid", 64'(out_valid), 64'h1);
        checkOutput("t4 out_data",  64'(out_data),  64'h88776655);
        idle(1);
        checkOutput("t4 pulse count", 64'(validPulses - v0), 64'd1);
        checkOutput("t4 err count",   64'(errPulses - e0),   64'd1);

        // Scenario 5: missing sync drops lock
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h32, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h34, 1'b0);
        checkOutput("t5 out_data", 64'(out_data), 64'h34333231);
        applyStimulus(8'h99, 1'b0);
        checkOutput("t5 sync_err", 64'(sync_err), 64'h1);
        checkOutput("t5 unlocked", 64'(locked),   64'h0);
        checkOutput("t5 slot_idx", 64'(slot_idx), 64'h0);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h13, 1'b0);
        checkOutput("t5 hunt locked",   64'(locked),   64'h0);
        checkOutput("t5 hunt sync_err", 64'(sync_err), 64'h0);
        checkOutput("t5 hunt slot_idx", 64'(slot_idx), 64'h0);
        checkOutput("t5 hunt data",     64'(out_data), 64'h34333231);
        applyStimulus(8'h77, 1'b1);
        checkOutput("t5 relocked", 64'(locked),   64'h1);
        checkOutput("t5 slot 1",   64'(slot_idx), 64'h1);

        // Scenario 6: asynchronous reset in the middle of a frame
        applyStimulus(8'h78, 1'b0);
        applyStimulus(8'h79, 1'b0);
        checkOutput("t6 pre slot", 64'(slot_idx), 64'h3);
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6 rst out_data",  64'(out_data),  64'h0);
        checkOutput("t6 rst out_valid", 64'(out_valid), 64'h0);
        checkOutput("t6 rst slot_idx",  64'(slot_idx),  64'h0);
        checkOutput("t6 rst locked",    64'(locked),    64'h0);
        checkOutput("t6 rst sync_err",  64'(sync_err),  64'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        v0 = validPulses;
        applyStimulus(8'hEF, 1'b1);
        checkOutput("t6 first slot", 64'(slot_idx),  64'h1);
        checkOutput("t6 no stale",   64'(out_valid), 64'h0);
        applyStimulus(8'hBE, 1'b0);
        applyStimulus(8'hAD, 1'b0);
        applyStimulus(8'hDE, 1'b0);
        checkOutput("t6 out_valid", 64'(out_valid), 64'h1);
        checkOutput("t6 out_data",  64'(out_data),  64'hDEADBEEF);
        idle(2);
        checkOutput("t6 pulse count", 64'(validPulses - v0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
